// File: rtl/fx2_fifo_sched.sv
// FX2 slave-FIFO bus scheduler: moves EP2 (OUT) words onto RX_* and TX_* words into EP6 (IN)
// over the shared FD bus, alternating directions in bounded bursts and committing short IN packets.
module fx2_fifo_sched #(
    parameter int         BURST_MAX    = 16,
    parameter int         PKT_WORDS    = 256,
    parameter int         IDLE_TIMEOUT = 64,
    parameter logic [1:0] EP_OUT_ADR   = 2'b00,
    parameter logic [1:0] EP_IN_ADR    = 2'b10
) (
    input  logic        IFCLK,
    input  logic        RESET_N,
    input  logic        CS,
    inout  wire  [15:0] FD,
    output logic        SLOE,
    output logic        SLRD,
    output logic        SLWR,
    output logic        FIFOADR0,
    output logic        FIFOADR1,
    output logic        PKTEND,
    input  logic        FLAGB,
    input  logic        FLAGC,
    input  logic [15:0] TX_DATA,
    input  logic        TX_VALID,
    output logic        TX_READY,
    output logic [15:0] RX_DATA,
    output logic        RX_VALID,
    input  logic        RX_READY
);

    localparam int BW = $clog2(BURST_MAX + 1);
    localparam int PW = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
    localparam int IW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX - 1);
    localparam logic [PW-1:0] PKT_LAST   = PW'(PKT_WORDS - 1);
    localparam logic [IW-1:0] IDLE_LAST  = IW'(IDLE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ADR,
        S_RD,
        S_WR_ADR,
        S_WR,
        S_PKTEND,
        S_TURN
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [BW-1:0]   burst_cnt;
    logic [PW-1:0]   pkt_cnt;
    logic [IW-1:0]   idle_cnt;
    logic            cur_in;
    logic            last_in;
    logic            rd_req;
    logic            wr_req;
    logic            rd_strobe;
    logic            wr_strobe;
    logic            pend_commit;
    logic            timeout_hit;
    logic            burst_end;
    logic            in_sel;

    assign rd_req      = FLAGC & (~RX_VALID | RX_READY);
    assign wr_req      = FLAGB & TX_VALID;
    assign pend_commit = (pkt_cnt != '0);
    assign timeout_hit = pend_commit & ~wr_req & (idle_cnt == IDLE_LAST);
    assign burst_end   = (burst_cnt == BURST_LAST);

    // The last word of a burst is strobed in the same cycle the FSM decides to leave,
    // so a full burst costs exactly BURST_MAX strobe cycles.
    always_comb begin
        state_next = state;
        rd_strobe  = 1'b0;
        wr_strobe  = 1'b0;
        case (state)
            S_IDLE: begin
                if (CS) begin
                    if (timeout_hit)
                        state_next = S_PKTEND;
                    else if (rd_req && (!wr_req || last_in))
                        state_next = S_RD_ADR;
                    else if (wr_req)
                        state_next = S_WR_ADR;
                end
            end
            S_RD_ADR: state_next = S_RD;
            S_RD: begin
                rd_strobe = rd_req;
                if (!rd_req || !CS || burst_end)
                    state_next = S_TURN;
            end
            S_WR_ADR: state_next = S_WR;
            S_WR: begin
                wr_strobe = wr_req;
                if (!wr_req || !CS || burst_end)
                    state_next = S_TURN;
            end
            S_PKTEND: state_next = S_TURN;
            S_TURN:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    assign in_sel                 = (state == S_WR_ADR) || (state == S_WR) || (state == S_PKTEND);
    assign {FIFOADR1, FIFOADR0}   = in_sel ? EP_IN_ADR : EP_OUT_ADR;
    assign SLOE                   = ~((state == S_RD_ADR) || (state == S_RD));
    assign SLRD                   = ~rd_strobe;
    assign SLWR                   = ~wr_strobe;
    assign TX_READY               = wr_strobe;
    assign PKTEND                 = ~(state == S_PKTEND);
    assign FD                     = (state == S_WR) ? TX_DATA : 'z;

    always_ff @(posedge IFCLK or negedge RESET_N) begin
        if (!RESET_N)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // Idle timer only runs while a partial packet waits and no writer is knocking.
    always_ff @(posedge IFCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            burst_cnt <= '0;
            pkt_cnt   <= '0;
            idle_cnt  <= '0;
            cur_in    <= 1'b1;
            last_in   <= 1'b1;
            RX_DATA   <= '0;
            RX_VALID  <= 1'b0;
        end else begin
            if (state == S_TURN)
                burst_cnt <= '0;
            else if (rd_strobe || wr_strobe)
                burst_cnt <= burst_cnt + 1'b1;

            if (state == S_PKTEND)
                pkt_cnt <= '0;
            else if (wr_strobe)
                pkt_cnt <= (pkt_cnt == PKT_LAST) ? '0 : pkt_cnt + 1'b1;

            if (wr_strobe || !pend_commit)
                idle_cnt <= '0;
            else if ((state == S_IDLE) && !wr_req && (idle_cnt != IDLE_LAST))
                idle_cnt <= idle_cnt + 1'b1;

            if ((state == S_IDLE) && (state_next == S_RD_ADR))
                cur_in <= 1'b0;
            else if ((state == S_IDLE) && (state_next == S_WR_ADR))
                cur_in <= 1'b1;

            if (state == S_TURN)
                last_in <= cur_in;

            if (rd_strobe) begin
                RX_DATA  <= FD;
                RX_VALID <= 1'b1;
            end else if (RX_READY) begin
                RX_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fx2_fifo_sched.sv
// Bench for fx2_fifo_sched: an FX2 endpoint environment, a phase-level reference model checked
// every cycle, and directed scenarios with hand-derived counts and timings.
module tb_fx2_fifo_sched;

    localparam int         BURST   = 16;
    localparam int         PKT     = 256;
    localparam int         TIMEOUT = 64;
    localparam logic [1:0] ADR_OUT = 2'b00;
    localparam logic [1:0] ADR_IN  = 2'b10;
    localparam int         BIG     = 1000000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs = 1'b0;
    logic        flagb = 1'b0;
    logic        flagc = 1'b0;
    logic        tx_valid = 1'b0;
    logic        rx_ready = 1'b0;
    logic [15:0] tx_data = '0;
    wire  [15:0] fd;
    logic        sloe, slrd, slwr, fifoadr0, fifoadr1, pktend, tx_ready, rx_valid;
    logic [15:0] rx_data;

    fx2_fifo_sched dut (
        .IFCLK(clk), .RESET_N(rst_n), .CS(cs), .FD(fd),
        .SLOE(sloe), .SLRD(slrd), .SLWR(slwr), .FIFOADR0(fifoadr0), .FIFOADR1(fifoadr1),
        .PKTEND(pktend), .FLAGB(flagb), .FLAGC(flagc),
        .TX_DATA(tx_data), .TX_VALID(tx_valid), .TX_READY(tx_ready),
        .RX_DATA(rx_data), .RX_VALID(rx_valid), .RX_READY(rx_ready)
    );

    always #5 clk = ~clk;

    // EP2 presents its head word whenever the scheduler opens the FX2 output drivers.
    logic [15:0] ep2_word = '0;
    logic [15:0] tx_word = 16'hA5A5;
    assign fd = (!sloe && rst_n) ? ep2_word : 'z;

    int n_checks = 0, n_errors = 0;
    int n_reads, n_writes, n_pktend, step_no, last_wr_step, first_pktend_step, reads_at_first_wr;
    logic [15:0] first_wr_word, last_wr_word;
    bit pop_pending, acc_pending;
    int p_flagc, p_flagb, p_txv, p_rxr, p_cs, rd_limit, wr_limit, flagb_cut;

    // Model: phase 0 idle, 1 address setup, 2 data moves, 3 commit, 4 bus turnaround.
    int          m_phase, m_words, m_pkt, m_idle;
    bit          m_in, m_last_in, m_rxv;
    logic [15:0] m_rxd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit pct(input int p);
        return int'($urandom_range(99)) < p;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_words = 0; m_pkt = 0; m_idle = 0;
        m_in = 1'b1; m_last_in = 1'b1; m_rxv = 1'b0; m_rxd = '0;
    endtask

    task automatic applyStimulus();
        if (pop_pending) ep2_word = ep2_word + 16'd1;
        if (acc_pending) tx_word = tx_word + 16'd1;
        pop_pending = 1'b0;
        acc_pending = 1'b0;
        flagc    = pct(p_flagc) && (n_reads < rd_limit);
        flagb    = pct(p_flagb) && (n_writes < flagb_cut);
        tx_valid = pct(p_txv) && (n_writes < wr_limit);
        rx_ready = pct(p_rxr);
        cs       = pct(p_cs);
        tx_data  = tx_word;
    endtask

    task automatic checkOutput();
        bit rdq, wrq, pending, moved, req;
        bit e_sloe, e_slrd, e_slwr, e_pktend, e_txr;
        logic [1:0] e_adr;
        int nphase;
        rdq = flagc && (!m_rxv || rx_ready);
        wrq = flagb && tx_valid;
        e_sloe = 1; e_slrd = 1; e_slwr = 1; e_pktend = 1; e_txr = 0; e_adr = ADR_OUT;
        if (m_phase == 1) begin
            if (m_in) e_adr = ADR_IN; else e_sloe = 0;
        end else if (m_phase == 2) begin
            if (m_in) begin e_adr = ADR_IN; e_slwr = !wrq; e_txr = wrq; end
            else begin e_sloe = 0; e_slrd = !rdq; end
        end else if (m_phase == 3) begin
            e_adr = ADR_IN; e_pktend = 0;
        end
        chk("sloe", sloe, e_sloe);
        chk("slrd", slrd, e_slrd);
        chk("slwr", slwr, e_slwr);
        chk("pktend", pktend, e_pktend);
        chk("tx_ready", tx_ready, e_txr);
        chk("fifoadr", {fifoadr1, fifoadr0}, e_adr);
        chk("rx_valid", rx_valid, m_rxv);
        chk("rx_data", rx_data, m_rxd);
        if (m_phase == 2 && m_in) chk("fd_write", fd, tx_data);

        step_no++;
        if (!slrd) n_reads++;
        if (!slwr) begin
            if (n_writes == 0) begin first_wr_word = fd; reads_at_first_wr = n_reads; end
            last_wr_word = fd;
            last_wr_step = step_no;
            n_writes++;
        end
        if (!pktend) begin
            n_pktend++;
            if (first_pktend_step == 0) first_pktend_step = step_no;
        end
        pop_pending = !slrd;
        acc_pending = tx_ready;

        pending = (m_pkt != 0);
        req     = m_in ? wrq : rdq;
        moved   = (m_phase == 2) && req;
        nphase  = m_phase;
        case (m_phase)
            0: if (cs) begin
                if (pending && !wrq && m_idle == TIMEOUT - 1) nphase = 3;
                else if (rdq && (!wrq || m_last_in)) begin nphase = 1; m_in = 0; end
                else if (wrq) begin nphase = 1; m_in = 1; end
            end
            1: nphase = 2;
            2: begin
                if (moved) m_words++;
                if (!req || !cs || m_words == BURST) nphase = 4;
            end
            3: nphase = 4;
            default: begin m_last_in = m_in; m_words = 0; nphase = 0; end
        endcase
        if (moved && !m_in) begin m_rxd = ep2_word; m_rxv = 1; end
        else if (rx_ready) m_rxv = 0;
        if (moved && m_in || !pending) m_idle = 0;
        else if (m_phase == 0 && !wrq && m_idle < TIMEOUT - 1) m_idle++;
        if (moved && m_in) m_pkt = (m_pkt + 1) % PKT;
        if (m_phase == 3) m_pkt = 0;
        m_phase = nphase;
    endtask

    task automatic step();
        applyStimulus();
        #1;
        checkOutput();
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        cs = 0; flagb = 0; flagc = 0; tx_valid = 0; rx_ready = 0; tx_data = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_sloe", sloe, 1);
        chk("rst_slrd", slrd, 1);
        chk("rst_slwr", slwr, 1);
        chk("rst_pktend", pktend, 1);
        chk("rst_fifoadr", {fifoadr1, fifoadr0}, ADR_OUT);
        chk("rst_tx_ready", tx_ready, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        model_reset();
        ep2_word = '0; tx_word = 16'hA5A5; pop_pending = 0; acc_pending = 0;
        n_reads = 0; n_writes = 0; n_pktend = 0; step_no = 0; last_wr_step = 0;
        first_pktend_step = 0; reads_at_first_wr = 0; first_wr_word = '0; last_wr_word = '0;
        p_flagc = 0; p_flagb = 0; p_txv = 0; p_rxr = 0; p_cs = 100;
        rd_limit = BIG; wr_limit = BIG; flagb_cut = BIG;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Continuous OUT stream: one full burst, then a fresh grant.
        doReset();
        p_flagc = 100; p_rxr = 100;
        run(20);
        chk("s1_reads_burst", n_reads, 16);
        chk("s1_last_word", rx_data, 16'd15);
        run(20);
        chk("s1_reads_regrant", n_reads, 32);
        chk("s1_last_word2", rx_data, 16'd31);

        // Continuous IN stream.
        doReset();
        p_flagb = 100; p_txv = 100; p_rxr = 100;
        run(20);
        chk("s2_writes", n_writes, 16);
        chk("s2_no_reads", n_reads, 0);
        chk("s2_first_word", first_wr_word, 16'hA5A5);
        chk("s2_last_word", last_wr_word, 16'hA5B4);

        // Both directions, 40 words each, alternating bursts.
        doReset();
        p_flagc = 100; p_flagb = 100; p_txv = 100; p_rxr = 100;
        rd_limit = 40; wr_limit = 40;
        run(200);
        chk("s3_reads", n_reads, 40);
        chk("s3_writes", n_writes, 40);
        chk("s3_reads_before_first_write", reads_at_first_wr, 16);

        // Short packet commit after the idle timeout.
        doReset();
        p_flagb = 100; p_txv = 100; wr_limit = 5;
        run(200);
        chk("s4_writes", n_writes, 5);
        chk("s4_pktend_count", n_pktend, 1);
        chk("s4_pktend_delay", first_pktend_step - last_wr_step, 67);

        // Exactly one full EP6 packet: hardware commits, no PKTEND.
        doReset();
        p_flagb = 100; p_txv = 100; wr_limit = PKT;
        run(500);
        chk("s4_full_writes", n_writes, 256);
        chk("s4_full_no_pktend", n_pktend, 0);

        // EP6 goes full after word 7, then recovers.
        doReset();
        p_flagb = 100; p_txv = 100; flagb_cut = 7;
        run(15);
        chk("s5_stall_writes", n_writes, 7);
        flagb_cut = BIG;
        run(19);
        chk("s5_resume_writes", n_writes, 23);

        // Sink back-pressure holds the read strobe off.
        doReset();
        p_flagc = 100; p_rxr = 0;
        run(30);
        chk("s6_reads", n_reads, 1);
        chk("s6_rx_valid", rx_valid, 1);
        chk("s6_rx_data", rx_data, 16'd0);

        // Asynchronous reset in the middle of a write burst.
        p_flagc = 0; p_flagb = 100; p_txv = 100; p_rxr = 100;
        run(6);
        chk("s6_in_write", slwr, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("s6_async_slwr", slwr, 1);
        chk("s6_async_tx_ready", tx_ready, 0);
        chk("s6_async_fifoadr", {fifoadr1, fifoadr0}, ADR_OUT);
        chk("s6_async_sloe", sloe, 1);
        doReset();
        run(150);
        chk("s6_no_pktend_after_reset", n_pktend, 0);

        // Randomised traffic against the model.
        for (int seg = 0; seg < 12; seg++) begin
            if (seg % 4 == 0) doReset();
            p_flagc = int'($urandom_range(100, 10));
            p_flagb = int'($urandom_range(100, 20));
            p_txv   = int'($urandom_range(100, 0));
            p_rxr   = int'($urandom_range(100, 10));
            p_cs    = int'($urandom_range(100, 60));
            run(300);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
